// File: rtl/imem_if.sv
// Instruction-memory request/response bundle between the fetch unit and memory.
//   req    : fetch request, held until rvalid
//   addr   : fetch address, stable while req is high
//   rvalid : read data valid
//   rdata  : instruction word
interface imem_if;
   localparam int unsigned XLEN = 32;

   logic            req;
   logic [XLEN-1:0] addr;
   logic            rvalid;
   logic [XLEN-1:0] rdata;

   modport master (output req, output addr, input rvalid, input rdata);
   modport slave  (input req, input addr, output rvalid, output rdata);
endinterface

// File: rtl/instr_fetch_unit.sv
// Fetch stage: holds the PC, fetches from instruction memory, presents a stable
// Instr/PC until the downstream stage accepts it, then selects the next PC.
//   clk, reset     : clock (rising edge), asynchronous active-high reset
//   PCSrc          : 00 PC+4, 01 PCTarget, 10 ALUResult, 11 PC+4
//   PCTarget       : branch/JAL target
//   ALUResult      : JALR target
//   Stall          : downstream not ready, hold current instruction
//   imem           : instruction-memory master port
//   Instr, PC      : current instruction and its address
//   PCPlus4        : PC+4, combinational from PC
//   InstrValid     : Instr/PC hold an unconsumed instruction
//   MisalignFault  : sticky, a selected next PC was not word aligned
module instr_fetch_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [1:0]   PCSrc,
   input  logic [31:0]  PCTarget,
   input  logic [31:0]  ALUResult,
   input  logic         Stall,
   imem_if.master       imem,
   output logic [31:0]  Instr,
   output logic [31:0]  PC,
   output logic [31:0]  PCPlus4,
   output logic         InstrValid,
   output logic         MisalignFault
);
   localparam int unsigned XLEN = 32;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_VALID = 2'd2,
      S_FAULT = 2'd3
   } state_t;

   state_t          state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] instr_q, instr_d;
   logic            fault_q, fault_d;
   logic [XLEN-1:0] next_pc;

   // State and datapath registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         pc_q    <= RESET_PC;
         instr_q <= NOP_INSTR;
         fault_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
         fault_q <= fault_d;
      end
   end

   // Next-PC selection; 11 falls back to sequential
   always_comb begin
      next_pc = pc_q + XLEN'(4);
      case (PCSrc)
         2'b01:   next_pc = PCTarget;
         2'b10:   next_pc = ALUResult;
         default: next_pc = pc_q + XLEN'(4);
      endcase
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      instr_d = instr_q;
      fault_d = fault_q;
      case (state_q)
         S_IDLE:  state_d = S_FETCH;
         S_FETCH: begin
            if (imem.rvalid) begin
               instr_d = imem.rdata;
               state_d = S_VALID;
            end
         end
         S_VALID: begin
            if (!Stall) begin
               if (next_pc[1:0] == 2'b00) begin
                  pc_d    = next_pc;
                  state_d = S_FETCH;
               end else begin
                  fault_d = 1'b1;
                  state_d = S_FAULT;
               end
            end
         end
         S_FAULT: state_d = S_FAULT;
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs decode from registered state only; no path from rvalid to req
   assign imem.req      = (state_q == S_FETCH);
   assign imem.addr     = pc_q;
   assign Instr         = instr_q;
   assign PC            = pc_q;
   assign PCPlus4       = pc_q + XLEN'(4);
   assign InstrValid    = (state_q == S_VALID);
   assign MisalignFault = fault_q;
endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;
   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  PCSrc;
   logic [31:0] PCTarget, ALUResult;
   logic        Stall;
   logic [31:0] instr1, pc1, pcp1, instr2, pc2, pcp2;
   logic        iv1, flt1, iv2, flt2;
   int          n_tests = 0;
   int          n_fail  = 0;

   imem_if if1 ();
   imem_if if2 ();

   instr_fetch_unit dut (
      .clk(clk), .reset(reset), .PCSrc(PCSrc), .PCTarget(PCTarget),
      .ALUResult(ALUResult), .Stall(Stall), .imem(if1),
      .Instr(instr1), .PC(pc1), .PCPlus4(pcp1), .InstrValid(iv1),
      .MisalignFault(flt1)
   );

   instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
      .clk(clk), .reset(reset), .PCSrc(PCSrc), .PCTarget(PCTarget),
      .ALUResult(ALUResult), .Stall(Stall), .imem(if2),
      .Instr(instr2), .PC(pc2), .PCPlus4(pcp2), .InstrValid(iv2),
      .MisalignFault(flt2)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic test_reset();
      reset = 1'b1; PCSrc = 2'b00; PCTarget = '0; ALUResult = '0; Stall = 1'b0;
      if1.rvalid = 1'b0; if1.rdata = '0; if2.rvalid = 1'b0; if2.rdata = '0;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_tests++; if (if1.req !== 1'b0) begin n_fail++; $display("FAIL reset_req cyc%0d: got %b exp 0", i, if1.req); end
      end
      n_tests++; if (pc1 !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h exp 00000000", pc1); end
      n_tests++; if (instr1 !== 32'h13) begin n_fail++; $display("FAIL reset_instr: got %h exp 00000013", instr1); end
      n_tests++; if (iv1 !== 1'b0 || flt1 !== 1'b0) begin n_fail++; $display("FAIL reset_flags: got iv=%b flt=%b exp 0 0", iv1, flt1); end
      n_tests++; if (pc2 !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL reset_pc2: got %h exp fffffffc", pc2); end
      reset = 1'b0;
      #1;
      n_tests++; if (if1.req !== 1'b0) begin n_fail++; $display("FAIL idle_req: got %b exp 0", if1.req); end
      tick();
      n_tests++; if (if1.req !== 1'b1 || if1.addr !== 32'h0) begin n_fail++; $display("FAIL first_fetch: got req=%b addr=%h exp 1 00000000", if1.req, if1.addr); end
   endtask

   task automatic test_zero_wait();
      if1.rvalid = 1'b1; if1.rdata = 32'h0050_0113;
      tick();
      n_tests++; if (iv1 !== 1'b1 || instr1 !== 32'h0050_0113 || pc1 !== 32'h0) begin n_fail++; $display("FAIL zw_valid0: got iv=%b instr=%h pc=%h exp 1 00500113 00000000", iv1, instr1, pc1); end
      n_tests++; if (if1.req !== 1'b0 || pcp1 !== 32'h4) begin n_fail++; $display("FAIL zw_req_pcp4: got req=%b pcp4=%h exp 0 00000004", if1.req, pcp1); end
      if1.rvalid = 1'b0;
      tick();
      n_tests++; if (if1.req !== 1'b1 || if1.addr !== 32'h4 || iv1 !== 1'b0) begin n_fail++; $display("FAIL zw_fetch1: got req=%b addr=%h iv=%b exp 1 00000004 0", if1.req, if1.addr, iv1); end
      if1.rvalid = 1'b1; if1.rdata = 32'h00A0_0193;
      tick();
      n_tests++; if (iv1 !== 1'b1 || instr1 !== 32'h00A0_0193 || pc1 !== 32'h4) begin n_fail++; $display("FAIL zw_valid1: got iv=%b instr=%h pc=%h exp 1 00a00193 00000004", iv1, instr1, pc1); end
      if1.rvalid = 1'b0;
      tick();
      n_tests++; if (if1.req !== 1'b1 || if1.addr !== 32'h8) begin n_fail++; $display("FAIL zw_fetch2: got req=%b addr=%h exp 1 00000008", if1.req, if1.addr); end
   endtask

   task automatic test_wait_states();
      for (int i = 0; i < 3; i++) begin
         tick();
         n_tests++; if (if1.req !== 1'b1 || if1.addr !== 32'h8 || iv1 !== 1'b0) begin n_fail++; $display("FAIL wait_hold cyc%0d: got req=%b addr=%h iv=%b exp 1 00000008 0", i, if1.req, if1.addr, iv1); end
      end
      if1.rvalid = 1'b1; if1.rdata = 32'h0020_8033;
      tick();
      n_tests++; if (iv1 !== 1'b1 || instr1 !== 32'h0020_8033 || pc1 !== 32'h8) begin n_fail++; $display("FAIL wait_valid: got iv=%b instr=%h pc=%h exp 1 00208033 00000008", iv1, instr1, pc1); end
      if1.rvalid = 1'b0;
      tick();
      tick();
      // reset while waiting on memory, with a late response arriving
      reset = 1'b1; if1.rvalid = 1'b1; if1.rdata = 32'hDEAD_BEEF;
      tick();
      tick();
      n_tests++; if (instr1 !== 32'h13 || pc1 !== 32'h0 || if1.req !== 1'b0) begin n_fail++; $display("FAIL wait_reset: got instr=%h pc=%h req=%b exp 00000013 00000000 0", instr1, pc1, if1.req); end
      reset = 1'b0;
      tick();
      n_tests++; if (instr1 !== 32'h13 || iv1 !== 1'b0 || if1.req !== 1'b1) begin n_fail++; $display("FAIL late_rvalid: got instr=%h iv=%b req=%b exp 00000013 0 1", instr1, iv1, if1.req); end
      if1.rvalid = 1'b0;
   endtask

   task automatic test_branch();
      if1.rvalid = 1'b1; if1.rdata = 32'h0000_006F;
      tick();
      PCSrc = 2'b01; PCTarget = 32'h100; if1.rvalid = 1'b0;
      tick();
      n_tests++; if (if1.req !== 1'b1 || if1.addr !== 32'h100) begin n_fail++; $display("FAIL br_target: got req=%b addr=%h exp 1 00000100", if1.req, if1.addr); end
      if1.rvalid = 1'b1; if1.rdata = 32'h0000_8067;
      tick();
      PCSrc = 2'b10; ALUResult = 32'h200; if1.rvalid = 1'b0;
      tick();
      n_tests++; if (if1.req !== 1'b1 || if1.addr !== 32'h200) begin n_fail++; $display("FAIL br_jalr: got req=%b addr=%h exp 1 00000200", if1.req, if1.addr); end
   endtask

   task automatic test_stall();
      logic [1:0] seq [3];
      seq[0] = 2'b01; seq[1] = 2'b10; seq[2] = 2'b00;
      Stall = 1'b1; PCSrc = 2'b00; if1.rvalid = 1'b1; if1.rdata = 32'h0040_0293;
      tick();
      n_tests++; if (iv1 !== 1'b1 || instr1 !== 32'h0040_0293 || pc1 !== 32'h200) begin n_fail++; $display("FAIL stall_in_fetch: got iv=%b instr=%h pc=%h exp 1 00400293 00000200", iv1, instr1, pc1); end
      if1.rvalid = 1'b0; PCTarget = 32'h300; ALUResult = 32'h400;
      for (int i = 0; i < 3; i++) begin
         PCSrc = seq[i];
         tick();
         n_tests++; if (iv1 !== 1'b1 || instr1 !== 32'h0040_0293 || pc1 !== 32'h200 || if1.req !== 1'b0) begin n_fail++; $display("FAIL stall_hold cyc%0d: got iv=%b instr=%h pc=%h req=%b exp 1 00400293 00000200 0", i, iv1, instr1, pc1, if1.req); end
      end
      Stall = 1'b0; PCSrc = 2'b01;
      tick();
      n_tests++; if (if1.req !== 1'b1 || if1.addr !== 32'h300) begin n_fail++; $display("FAIL stall_release: got req=%b addr=%h exp 1 00000300", if1.req, if1.addr); end
   endtask

   task automatic test_misalign();
      if1.rvalid = 1'b1; if1.rdata = 32'h0000_0013;
      tick();
      PCSrc = 2'b11; PCTarget = 32'h500; ALUResult = 32'h600; if1.rvalid = 1'b0;
      tick();
      n_tests++; if (if1.req !== 1'b1 || if1.addr !== 32'h304) begin n_fail++; $display("FAIL pcsrc11: got req=%b addr=%h exp 1 00000304", if1.req, if1.addr); end
      if1.rvalid = 1'b1; if1.rdata = 32'h0000_8067;
      tick();
      PCSrc = 2'b10; ALUResult = 32'h202; if1.rvalid = 1'b0;
      tick();
      n_tests++; if (flt1 !== 1'b1 || if1.req !== 1'b0 || iv1 !== 1'b0 || pc1 !== 32'h304) begin n_fail++; $display("FAIL misalign: got flt=%b req=%b iv=%b pc=%h exp 1 0 0 00000304", flt1, if1.req, iv1, pc1); end
      if1.rvalid = 1'b1; ALUResult = 32'h400;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_tests++; if (flt1 !== 1'b1 || if1.req !== 1'b0) begin n_fail++; $display("FAIL fault_sticky cyc%0d: got flt=%b req=%b exp 1 0", i, flt1, if1.req); end
      end
      if1.rvalid = 1'b0; reset = 1'b1;
      tick();
      n_tests++; if (flt1 !== 1'b0) begin n_fail++; $display("FAIL fault_clear: got %b exp 0", flt1); end
   endtask

   task automatic test_wrap();
      PCSrc = 2'b00; Stall = 1'b0;
      tick();
      reset = 1'b0;
      tick();
      n_tests++; if (if2.req !== 1'b1 || if2.addr !== 32'hFFFF_FFFC || pcp2 !== 32'h0) begin n_fail++; $display("FAIL wrap_fetch: got req=%b addr=%h pcp4=%h exp 1 fffffffc 00000000", if2.req, if2.addr, pcp2); end
      if2.rvalid = 1'b1; if2.rdata = 32'h0000_0013;
      tick();
      n_tests++; if (iv2 !== 1'b1 || pc2 !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_valid: got iv=%b pc=%h exp 1 fffffffc", iv2, pc2); end
      if2.rvalid = 1'b0;
      tick();
      n_tests++; if (if2.req !== 1'b1 || if2.addr !== 32'h0 || flt2 !== 1'b0) begin n_fail++; $display("FAIL wrap_next: got req=%b addr=%h flt=%b exp 1 00000000 0", if2.req, if2.addr, flt2); end
   endtask

   initial begin
      test_reset();
      test_zero_wait();
      test_wait_states();
      test_branch();
      test_stall();
      test_misalign();
      test_wrap();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
